// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared CPU fetch-sequencer types and defaults
// Contents:
//   seq_state_e       fetch sequencer state encoding
//   RESET_PC_DEFAULT  PC presented on the first fetch after reset
//   PC_STEP_DEFAULT   sequential PC increment in bytes
//   pc_add()          modulo-2^32 PC addition
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // Plain 32-bit add; the carry out is dropped so the PC wraps at 2^32.
  function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch sequencer control bundle between core and sequencer
// Signals:
//   pc_cur_i, imem_ack_i, load_use_i, branch_taken_i, branch_target_i  core -> sequencer
//   pc_Write_o, pc_next_o, imem_req_o, ifid_write_o, ifid_flush_o,
//   stall_cnt_o                                                        sequencer -> core
// Modports: master = sequencer side, slave = core/pipeline side.
interface pc_sequencer_if;

  logic [31:0] pc_cur_i;
  logic        imem_ack_i;
  logic        load_use_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;

  logic        pc_Write_o;
  logic [31:0] pc_next_o;
  logic        imem_req_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic [15:0] stall_cnt_o;

  modport master (
    input  pc_cur_i, imem_ack_i, load_use_i, branch_taken_i, branch_target_i,
    output pc_Write_o, pc_next_o, imem_req_o, ifid_write_o, ifid_flush_o, stall_cnt_o
  );

  modport slave (
    output pc_cur_i, imem_ack_i, load_use_i, branch_taken_i, branch_target_i,
    input  pc_Write_o, pc_next_o, imem_req_o, ifid_write_o, ifid_flush_o, stall_cnt_o
  );

endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// rtl/pc_sequencer_sat_counter.sv - saturating up-counter
// Ports:
//   clk_i    clock, counts on posedge
//   rst_i    asynchronous active-low reset, clears the count
//   inc_i    increment request for this cycle
//   count_o  current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction fetch PC sequencer
// Ports:
//   clk_i   single clock, state updates on posedge
//   rst_i   asynchronous active-low reset
//   bus     pc_sequencer_if.master: PC/imem/hazard/branch inputs,
//           PC load, fetch request, IF/ID enable/clear and stall count outputs
// Parameters:
//   RESET_PC  PC loaded in the boot cycle
//   PC_STEP   sequential PC increment in bytes
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_sequencer_if.master bus
);

  localparam logic [31:0] STEP32 = 32'(PC_STEP);

  seq_state_e  state_q, state_d;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;

  logic        pend_set, pend_clr;
  logic        stall_inc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        ifid_write;
  logic        ifid_flush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // A branch resolved while no instruction word is arriving is parked here
  // until the next ack; a newer branch replaces the parked target.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else if (pend_clr) begin
      pend_valid_q  <= 1'b0;
    end else if (pend_set) begin
      pend_valid_q  <= 1'b1;
      pend_target_q <= bus.branch_target_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b1;
    pc_next    = bus.pc_cur_i;
    imem_req   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_write = 1'b0;
        pc_next  = RESET_PC;
        state_d  = ST_FETCH;
      end

      ST_FETCH, ST_WAIT: begin
        imem_req = 1'b1;
        if (bus.imem_ack_i) begin
          pc_write   = 1'b0;
          ifid_write = 1'b1;
          pend_clr   = 1'b1;
          state_d    = ST_FETCH;
          if (bus.branch_taken_i) begin
            // A fresh branch outranks both a parked target and a load-use stall.
            pc_next    = bus.branch_target_i;
            ifid_flush = 1'b1;
          end else if (pend_valid_q) begin
            // The fetched word is wrong-path; the flush drops it.
            pc_next    = pend_target_q;
            ifid_flush = 1'b1;
          end else begin
            pc_next = pc_add(bus.pc_cur_i, STEP32);
            if (bus.load_use_i) begin
              state_d = ST_HOLD;
            end
          end
        end else begin
          state_d  = ST_WAIT;
          pend_set = bus.branch_taken_i;
        end
      end

      ST_HOLD: begin
        state_d  = ST_FETCH;
        pend_set = bus.branch_taken_i;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    stall_inc = pc_write && (state_q != ST_BOOT);

    // Reset overrides outputs combinationally so imem_req_o drops without
    // waiting for a clock edge, and any ack seen during reset is ignored.
    if (!rst_i) begin
      pc_write   = 1'b1;
      pc_next    = RESET_PC;
      imem_req   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      stall_inc  = 1'b0;
    end
  end

  sat_counter #(
    .WIDTH(16)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (stall_inc),
    .count_o(bus.stall_cnt_o)
  );

  assign bus.pc_Write_o   = pc_write;
  assign bus.pc_next_o    = pc_next;
  assign bus.imem_req_o   = imem_req;
  assign bus.ifid_write_o = ifid_write;
  assign bus.ifid_flush_o = ifid_flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic clk;
  logic rst;

  pc_sequencer_if bus_if();

  pc_sequencer #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        ack;
    logic        lu;
    logic        bt;
    logic [31:0] tgt;
    logic        e_pcw;
    logic [31:0] e_pcn;
    logic        e_req;
    logic        e_ifw;
    logic        e_fl;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic ack,
                              input logic lu, input logic bt, input logic [31:0] tgt,
                              input logic pcw, input logic [31:0] pcn, input logic req,
                              input logic ifw, input logic fl, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.pc = pc; v.ack = ack; v.lu = lu; v.bt = bt; v.tgt = tgt;
    v.e_pcw = pcw; v.e_pcn = pcn; v.e_req = req; v.e_ifw = ifw; v.e_fl = fl; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic ack,
                       input logic lu, input logic bt, input logic [31:0] tgt);
    rst                     = r;
    bus_if.pc_cur_i         = pc;
    bus_if.imem_ack_i       = ack;
    bus_if.load_use_i       = lu;
    bus_if.branch_taken_i   = bt;
    bus_if.branch_target_i  = tgt;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".pc_Write"}, 32'(bus_if.pc_Write_o),   32'(v.e_pcw));
    check({tag, ".pc_next"},  bus_if.pc_next_o,         v.e_pcn);
    check({tag, ".imem_req"}, 32'(bus_if.imem_req_o),   32'(v.e_req));
    check({tag, ".ifid_wr"},  32'(bus_if.ifid_write_o), 32'(v.e_ifw));
    check({tag, ".ifid_fl"},  32'(bus_if.ifid_flush_o), 32'(v.e_fl));
    check({tag, ".stall"},    32'(bus_if.stall_cnt_o),  32'(v.e_cnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //              rst pc            ack lu bt tgt            pcw pcn           req ifw fl cnt
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0,          1, 32'h0,         0,  0, 0, 16'd0));  // in reset, ack ignored
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0,          1, 32'h0,         0,  0, 0, 16'd0));
    vecs.push_back(mk(1, 32'h0,        1, 0, 0, 32'h0,          0, 32'h0,         0,  0, 0, 16'd0));  // BOOT
    vecs.push_back(mk(1, 32'h0,        1, 0, 0, 32'h0,          0, 32'h4,         1,  1, 0, 16'd0));
    vecs.push_back(mk(1, 32'h4,        1, 0, 0, 32'h0,          0, 32'h8,         1,  1, 0, 16'd0));
    vecs.push_back(mk(1, 32'h8,        1, 0, 0, 32'h0,          0, 32'hC,         1,  1, 0, 16'd0));
    vecs.push_back(mk(1, 32'hC,        1, 0, 1, 32'h8,          0, 32'h8,         1,  1, 1, 16'd0));  // immediate redirect
    vecs.push_back(mk(1, 32'h8,        0, 0, 0, 32'h0,          1, 32'h8,         1,  0, 0, 16'd0));  // ack delayed 3
    vecs.push_back(mk(1, 32'h8,        0, 0, 0, 32'h0,          1, 32'h8,         1,  0, 0, 16'd1));
    vecs.push_back(mk(1, 32'h8,        0, 0, 0, 32'h0,          1, 32'h8,         1,  0, 0, 16'd2));
    vecs.push_back(mk(1, 32'h8,        1, 0, 0, 32'h0,          0, 32'hC,         1,  1, 0, 16'd3));
    vecs.push_back(mk(1, 32'hC,        0, 0, 0, 32'h0,          1, 32'hC,         1,  0, 0, 16'd3));
    vecs.push_back(mk(1, 32'hC,        0, 0, 1, 32'h100,        1, 32'hC,         1,  0, 0, 16'd4));  // branch in WAIT
    vecs.push_back(mk(1, 32'hC,        0, 0, 0, 32'h0,          1, 32'hC,         1,  0, 0, 16'd5));
    vecs.push_back(mk(1, 32'hC,        1, 0, 0, 32'h0,          0, 32'h100,       1,  1, 1, 16'd6));  // pending applied
    vecs.push_back(mk(1, 32'h100,      1, 0, 0, 32'h0,          0, 32'h104,       1,  1, 0, 16'd6));  // pending cleared
    vecs.push_back(mk(1, 32'h104,      0, 0, 1, 32'h200,        1, 32'h104,       1,  0, 0, 16'd6));
    vecs.push_back(mk(1, 32'h104,      0, 0, 1, 32'h300,        1, 32'h104,       1,  0, 0, 16'd7));  // last wins
    vecs.push_back(mk(1, 32'h104,      1, 0, 0, 32'h0,          0, 32'h300,       1,  1, 1, 16'd8));
    vecs.push_back(mk(1, 32'h300,      1, 1, 1, 32'h40,         0, 32'h40,        1,  1, 1, 16'd8));  // branch beats load-use
    vecs.push_back(mk(1, 32'h40,       1, 0, 0, 32'h0,          0, 32'h44,        1,  1, 0, 16'd8));  // no HOLD
    vecs.push_back(mk(1, 32'h44,       1, 1, 0, 32'h0,          0, 32'h48,        1,  1, 0, 16'd8));  // load-use
    vecs.push_back(mk(1, 32'h48,       1, 0, 0, 32'h0,          1, 32'h48,        0,  0, 0, 16'd8));  // HOLD
    vecs.push_back(mk(1, 32'h48,       1, 0, 0, 32'h0,          0, 32'h4C,        1,  1, 0, 16'd9));
    vecs.push_back(mk(1, 32'hFFFF_FFFC,1, 0, 0, 32'h0,          0, 32'h0,         1,  1, 0, 16'd9));  // wrap
    vecs.push_back(mk(1, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,         1,  0, 0, 16'd9));
    vecs.push_back(mk(1, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,         1,  0, 0, 16'd10)); // in WAIT

    drive(0, 32'h0, 1, 0, 0, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rst, vecs[i].pc, vecs[i].ack, vecs[i].lu, vecs[i].bt, vecs[i].tgt);
      #3;
      check_outs($sformatf("v%0d", i), vecs[i]);
    end

    // Long WAIT drives the stall counter into saturation; count is 11 entering the loop.
    drive(1, 32'h0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 65530; i++) @(posedge clk);
    #4;
    check("sat.stall", 32'(bus_if.stall_cnt_o), 32'h0000_FFFF);
    check("sat.req",   32'(bus_if.imem_req_o),  32'h1);
    @(posedge clk);
    #4;
    check("sat.hold", 32'(bus_if.stall_cnt_o), 32'h0000_FFFF);

    // Reset pulsed mid-WAIT, away from any clock edge.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst.req_drop", 32'(bus_if.imem_req_o), 32'h0);
    check("rst.pcw",      32'(bus_if.pc_Write_o), 32'h1);
    check("rst.stall",    32'(bus_if.stall_cnt_o), 32'h0);
    bus_if.imem_ack_i = 1'b1;
    @(posedge clk);
    #4;
    check("rst.ack_ign_req", 32'(bus_if.imem_req_o),   32'h0);
    check("rst.ack_ign_ifw", 32'(bus_if.ifid_write_o), 32'h0);
    check("rst.pcn",         bus_if.pc_next_o,         32'h0);
    @(posedge clk);
    #1;
    drive(1, 32'h44, 1, 0, 0, 32'h0);
    #3;
    check("boot.pcw", 32'(bus_if.pc_Write_o), 32'h0);
    check("boot.pcn", bus_if.pc_next_o,       32'h0);
    check("boot.req", 32'(bus_if.imem_req_o), 32'h0);
    @(posedge clk);
    #1;
    drive(1, 32'h0, 1, 0, 0, 32'h0);
    #3;
    check("post.pcn", bus_if.pc_next_o,        32'h4);
    check("post.fl",  32'(bus_if.ifid_flush_o), 32'h0);
    check("post.req", 32'(bus_if.imem_req_o),  32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
